stonyman_frame_sequencer: RTL and testbench

//  Frame-level scheduler for a Stonyman image capture. Walks the chip's row/column pointers
//  (resv/incv/resp/incp pulses) and issues one adc_capture_start per pixel. Each start is issued

---
 rtl/stonyman_frame_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_stonyman_frame_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/stonyman_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : stonyman_frame_sequencer
// Description : Frame-level scheduler for a Stonyman capture. Walks the
//               sensor row/column pointers (resv/incv/resp/incp), waits for
//               each pixel to settle and for FIFO room, then issues one
//               adc_capture_start per pixel. Guards each conversion with a
//               timeout.
// Ports       : clk, reset (async, active-low)
//               frame_start, frame_abort, fifo_full, adc_capture_done (in)
//               adc_capture_start, newline_sample, resv, incv, resp, incp,
//               row_idx[6:0], col_idx[6:0], frame_busy, frame_done,
//               timeout_err (out, all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module stonyman_frame_sequencer #(
    parameter int ROWS          = 112,
    parameter int COLS          = 112,
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int ADC_TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       frame_abort,
    input  logic       fifo_full,
    input  logic       adc_capture_done,
    output logic       adc_capture_start,
    output logic       newline_sample,
    output logic       resv,
    output logic       incv,
    output logic       resp,
    output logic       incp,
    output logic [6:0] row_idx,
    output logic [6:0] col_idx,
    output logic       frame_busy,
    output logic       frame_done,
    output logic       timeout_err
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_RESV      = 4'd1,
        S_ROW_START = 4'd2,
        S_RESP      = 4'd3,
        S_SETTLE    = 4'd4,
        S_WAIT_FIFO = 4'd5,
        S_START     = 4'd6,
        S_WAIT_ADC  = 4'd7,
        S_INCP      = 4'd8,
        S_INCV      = 4'd9,
        S_DONE      = 4'd10
    } state_t;

    localparam logic [7:0] c_PULSE_HI_LAST = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] c_PULSE_LAST    = 8'(2 * PULSE_CYCLES - 1);
    localparam logic [7:0] c_SETTLE_LAST   = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] c_TIMEOUT_LAST  = 8'(ADC_TIMEOUT - 1);
    localparam logic [6:0] c_ROW_LAST      = 7'(ROWS - 1);
    localparam logic [6:0] c_COL_LAST      = 7'(COLS - 1);

    state_t     r_state;
    // Shared timer: pointer pulse phase, settle wait and ADC timeout.
    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state           <= S_IDLE;
            r_cnt             <= 8'd0;
            adc_capture_start <= 1'b0;
            newline_sample    <= 1'b0;
            resv              <= 1'b0;
            incv              <= 1'b0;
            resp              <= 1'b0;
            incp              <= 1'b0;
            row_idx           <= 7'd0;
            col_idx           <= 7'd0;
            frame_busy        <= 1'b0;
            frame_done        <= 1'b0;
            timeout_err       <= 1'b0;
        end else begin
            // Single-cycle strobes default low.
            adc_capture_start <= 1'b0;
            newline_sample    <= 1'b0;
            frame_done        <= 1'b0;

            if (r_state != S_IDLE && frame_abort) begin
                r_state    <= S_IDLE;
                resv       <= 1'b0;
                incv       <= 1'b0;
                resp       <= 1'b0;
                incp       <= 1'b0;
                frame_busy <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (frame_start) begin
                            r_state     <= S_RESV;
                            resv        <= 1'b1;
                            r_cnt       <= 8'd0;
                            row_idx     <= 7'd0;
                            col_idx     <= 7'd0;
                            timeout_err <= 1'b0;
                            frame_busy  <= 1'b1;
                        end
                    end

                    // Pointer pulse states: output high for the first half
                    // of the window, low for the second half, then exit.
                    S_RESV, S_RESP, S_INCP, S_INCV: begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == c_PULSE_HI_LAST) begin
                            resv <= 1'b0;
                            incv <= 1'b0;
                            resp <= 1'b0;
                            incp <= 1'b0;
                        end
                        if (r_cnt == c_PULSE_LAST) begin
                            r_cnt <= 8'd0;
                            if (r_state == S_RESV || r_state == S_INCV) begin
                                r_state        <= S_ROW_START;
                                newline_sample <= 1'b1;
                                col_idx        <= 7'd0;
                            end else begin
                                r_state <= S_SETTLE;
                            end
                        end
                    end

                    S_ROW_START: begin
                        r_state <= S_RESP;
                        resp    <= 1'b1;
                        r_cnt   <= 8'd0;
                    end

                    S_SETTLE: begin
                        if (r_cnt == c_SETTLE_LAST) begin
                            r_state <= S_WAIT_FIFO;
                            r_cnt   <= 8'd0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end

                    S_WAIT_FIFO: begin
                        if (!fifo_full) begin
                            r_state           <= S_START;
                            adc_capture_start <= 1'b1;
                        end
                    end

                    S_START: begin
                        r_state <= S_WAIT_ADC;
                        r_cnt   <= 8'd0;
                    end

                    // r_cnt counts completed WAIT_ADC cycles; done on the
                    // final allowed cycle still beats the timeout.
                    S_WAIT_ADC: begin
                        if (adc_capture_done) begin
                            r_cnt <= 8'd0;
                            if (col_idx < c_COL_LAST) begin
                                r_state <= S_INCP;
                                incp    <= 1'b1;
                                col_idx <= col_idx + 7'd1;
                            end else if (row_idx < c_ROW_LAST) begin
                                r_state <= S_INCV;
                                incv    <= 1'b1;
                                row_idx <= row_idx + 7'd1;
                            end else begin
                                r_state    <= S_DONE;
                                frame_done <= 1'b1;
                            end
                        end else if (r_cnt == c_TIMEOUT_LAST) begin
                            r_state     <= S_IDLE;
                            timeout_err <= 1'b1;
                            frame_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end

                    S_DONE: begin
                        r_state    <= S_IDLE;
                        frame_busy <= 1'b0;
                    end

                    default: begin
                        r_state    <= S_IDLE;
                        frame_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stonyman_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stonyman_frame_sequencer
// Description : Directed self-checking bench for stonyman_frame_sequencer
//               (ROWS=2, COLS=3, PULSE=2, SETTLE=4, ADC latency 10).
//               Cycle k=1 is the first cycle after frame_start is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stonyman_frame_sequencer;

    localparam int c_ROWS = 2;
    localparam int c_COLS = 3;
    localparam int c_LAT  = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_start = 1'b0;
    logic       frame_abort = 1'b0;
    logic       fifo_full = 1'b0;
    logic       adc_capture_done;
    logic       adc_capture_start, newline_sample;
    logic       resv, incv, resp, incp;
    logic [6:0] row_idx, col_idx;
    logic       frame_busy, frame_done, timeout_err;

    always #5 clk = ~clk;

    stonyman_frame_sequencer #(
        .ROWS(c_ROWS), .COLS(c_COLS), .PULSE_CYCLES(2),
        .SETTLE_CYCLES(4), .ADC_TIMEOUT(255)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .frame_abort(frame_abort), .fifo_full(fifo_full),
        .adc_capture_done(adc_capture_done),
        .adc_capture_start(adc_capture_start), .newline_sample(newline_sample),
        .resv(resv), .incv(incv), .resp(resp), .incp(incp),
        .row_idx(row_idx), .col_idx(col_idx), .frame_busy(frame_busy),
        .frame_done(frame_done), .timeout_err(timeout_err)
    );

    // ADC model: done is high for one cycle, c_LAT cycles after the start cycle.
    logic adc_done_model = 1'b0;
    logic stray_done = 1'b0;
    logic adc_en = 1'b1;
    int   adc_cnt = 0;
    assign adc_capture_done = adc_done_model | stray_done;

    always @(negedge clk) begin
        adc_done_model = 1'b0;
        if (adc_capture_start) begin
            adc_cnt = c_LAT;
        end else if (adc_cnt > 0) begin
            adc_cnt = adc_cnt - 1;
            if (adc_cnt == 0 && adc_en) adc_done_model = 1'b1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Scenario event cycles (-1 = unused).
    int stray_start_cyc, stray_done_cyc, fifo_on, fifo_off, abort_cyc, reset_cyc;
    // Observations from run_frame.
    int starts_at [8];
    int n_start, n_newline, n_resv, n_incv, n_resp, n_incp, n_overlap, n_done;
    int done_cyc, err_cyc, end_cyc;
    logic        r1_resv;
    logic [6:0]  r1_row;
    logic [22:0] outs_at_reset;

    function automatic logic [22:0] all_outs();
        return {adc_capture_start, newline_sample, resv, incv, resp, incp,
                row_idx, col_idx, frame_busy, frame_done, timeout_err};
    endfunction

    task automatic clear_scenario();
        stray_start_cyc = -1; stray_done_cyc = -1; fifo_on = -1; fifo_off = -1;
        abort_cyc = -1; reset_cyc = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Starts a frame and observes it cycle by cycle until frame_busy drops
    // (or the scheduled reset fires, or the cycle budget runs out).
    task automatic run_frame(input int max_cyc);
        logic p_resv, p_incv, p_resp, p_incp;
        p_resv = 0; p_incv = 0; p_resp = 0; p_incp = 0;
        n_start = 0; n_newline = 0; n_resv = 0; n_incv = 0; n_resp = 0;
        n_incp = 0; n_overlap = 0; n_done = 0;
        done_cyc = -1; err_cyc = -1; end_cyc = -1;
        for (int i = 0; i < 8; i++) starts_at[i] = -1;
        frame_start = 1'b1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (k == 1) begin r1_resv = resv; r1_row = row_idx; end
            if (resv && !p_resv) n_resv++;
            if (incv && !p_incv) n_incv++;
            if (resp && !p_resp) n_resp++;
            if (incp && !p_incp) n_incp++;
            p_resv = resv; p_incv = incv; p_resp = resp; p_incp = incp;
            if ($countones({resv, incv, resp, incp}) > 1) n_overlap++;
            if (newline_sample) n_newline++;
            if (adc_capture_start) begin
                if (n_start < 8) starts_at[n_start] = k;
                n_start++;
            end
            if (frame_done) begin n_done++; if (done_cyc < 0) done_cyc = k; end
            if (timeout_err && err_cyc < 0) err_cyc = k;
            frame_start = (k == stray_start_cyc);
            fifo_full   = (k >= fifo_on && k < fifo_off);
            stray_done  = (k == stray_done_cyc);
            frame_abort = (k == abort_cyc);
            if (k == reset_cyc) begin
                #2 reset = 1'b0;
                #1 outs_at_reset = all_outs();
                end_cyc = k;
                break;
            end
            if (!frame_busy) begin end_cyc = k; break; end
        end
        frame_start = 1'b0; fifo_full = 1'b0; stray_done = 1'b0; frame_abort = 1'b0;
    endtask

    task automatic test_reset();
        idle(3);
        n_tests++; if (all_outs() !== 23'd0) begin n_fail++; $display("FAIL reset_outs: got %h, expected 0", all_outs()); end
        reset = 1'b1;
        idle(3);
        n_tests++; if (all_outs() !== 23'd0) begin n_fail++; $display("FAIL post_reset_idle: got %h, expected 0", all_outs()); end
    endtask

    task automatic test_full_frame();
        clear_scenario();
        run_frame(400);
        n_tests++; if (r1_resv !== 1'b1) begin n_fail++; $display("FAIL resv_first_cycle: got %0d, expected 1", r1_resv); end
        n_tests++; if (n_start != 6) begin n_fail++; $display("FAIL starts: got %0d, expected 6", n_start); end
        n_tests++; if (n_newline != 2) begin n_fail++; $display("FAIL newlines: got %0d, expected 2", n_newline); end
        n_tests++; if (n_resv != 1 || n_incv != 1) begin n_fail++; $display("FAIL resv_incv: got %0d/%0d, expected 1/1", n_resv, n_incv); end
        n_tests++; if (n_resp != 2 || n_incp != 4) begin n_fail++; $display("FAIL resp_incp: got %0d/%0d, expected 2/4", n_resp, n_incp); end
        n_tests++; if (n_overlap != 0) begin n_fail++; $display("FAIL pointer_overlap: got %0d, expected 0", n_overlap); end
        n_tests++; if (starts_at[0] != 15 || starts_at[1] != 35) begin n_fail++; $display("FAIL start_timing: got %0d/%0d, expected 15/35", starts_at[0], starts_at[1]); end
        n_tests++; if (n_done != 1 || done_cyc != 131) begin n_fail++; $display("FAIL frame_done: got %0d at %0d, expected 1 at 131", n_done, done_cyc); end
        n_tests++; if (row_idx !== 7'd1 || col_idx !== 7'd2) begin n_fail++; $display("FAIL final_idx: got %0d/%0d, expected 1/2", row_idx, col_idx); end
        n_tests++; if (end_cyc != 132 || frame_busy !== 1'b0) begin n_fail++; $display("FAIL busy_end: got %0d busy=%0d, expected 132 busy=0", end_cyc, frame_busy); end
    endtask

    task automatic test_fifo_stall();
        clear_scenario();
        fifo_on = 26; fifo_off = 54;   // WAIT_FIFO of pixel (0,1) sees 20 full cycles
        run_frame(400);
        n_tests++; if (starts_at[1] != 55) begin n_fail++; $display("FAIL fifo_start: got %0d, expected 55", starts_at[1]); end
        n_tests++; if (n_start != 6 || done_cyc != 151) begin n_fail++; $display("FAIL fifo_frame: got %0d starts done@%0d, expected 6 done@151", n_start, done_cyc); end
    endtask

    task automatic test_timeout();
        clear_scenario();
        adc_en = 1'b0;
        run_frame(400);
        adc_en = 1'b1;
        // Start at 15, 255 WAIT_ADC cycles (16..270), flag visible from 271.
        n_tests++; if (err_cyc != 271) begin n_fail++; $display("FAIL timeout_cycle: got %0d, expected 271", err_cyc); end
        n_tests++; if (end_cyc != 271 || n_done != 0 || n_start != 1) begin n_fail++; $display("FAIL timeout_exit: got end=%0d done=%0d starts=%0d, expected 271/0/1", end_cyc, n_done, n_start); end
        idle(5);
        n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %0d, expected 1", timeout_err); end
        clear_scenario();
        abort_cyc = 3;
        run_frame(50);
        n_tests++; if (timeout_err !== 1'b0 || err_cyc != -1) begin n_fail++; $display("FAIL timeout_clear: got %0d (seen@%0d), expected 0", timeout_err, err_cyc); end
    endtask

    task automatic test_abort();
        clear_scenario();
        abort_cyc = 91;                // first incp cycle of row 1
        run_frame(400);
        n_tests++; if (end_cyc != 92 || incp !== 1'b0) begin n_fail++; $display("FAIL abort_incp: got end=%0d incp=%0d, expected 92/0", end_cyc, incp); end
        n_tests++; if (n_done != 0 || row_idx !== 7'd1) begin n_fail++; $display("FAIL abort_state: got done=%0d row=%0d, expected 0/1", n_done, row_idx); end
        idle(15);
        clear_scenario();
        run_frame(400);
        n_tests++; if (r1_resv !== 1'b1 || r1_row !== 7'd0) begin n_fail++; $display("FAIL abort_restart: got resv=%0d row=%0d, expected 1/0", r1_resv, r1_row); end
        n_tests++; if (done_cyc != 131) begin n_fail++; $display("FAIL restart_done: got %0d, expected 131", done_cyc); end
        idle(15);
        clear_scenario();
        abort_cyc = 25;                // coincides with first adc_capture_done
        run_frame(400);
        n_tests++; if (end_cyc != 26 || n_incp != 0 || n_done != 0) begin n_fail++; $display("FAIL abort_vs_done: got end=%0d incp=%0d done=%0d, expected 26/0/0", end_cyc, n_incp, n_done); end
        idle(15);
    endtask

    task automatic test_ignored_inputs();
        clear_scenario();
        stray_start_cyc = 40;
        stray_done_cyc  = 11;          // pixel (0,0) SETTLE
        run_frame(400);
        n_tests++; if (n_start != 6 || starts_at[0] != 15) begin n_fail++; $display("FAIL ignored_starts: got %0d first@%0d, expected 6 first@15", n_start, starts_at[0]); end
        n_tests++; if (done_cyc != 131 || n_done != 1) begin n_fail++; $display("FAIL ignored_done: got %0d x%0d, expected 131 x1", done_cyc, n_done); end
        idle(15);
    endtask

    task automatic test_async_reset();
        clear_scenario();
        reset_cyc = 20;                // mid WAIT_ADC of pixel (0,0)
        run_frame(400);
        n_tests++; if (outs_at_reset !== 23'd0) begin n_fail++; $display("FAIL async_reset_outs: got %h, expected 0", outs_at_reset); end
        @(negedge clk);
        reset = 1'b1;
        idle(15);
        n_tests++; if (all_outs() !== 23'd0) begin n_fail++; $display("FAIL reset_release_idle: got %h, expected 0", all_outs()); end
    endtask

    initial begin
        clear_scenario();
        test_reset();
        test_full_frame();
        idle(15);
        test_fifo_stall();
        idle(15);
        test_timeout();
        idle(15);
        test_abort();
        test_ignored_inputs();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
